imem_loader: RTL and testbench

- Program loader: the write-side counterpart of the CPU's instruction-memory fetch path.
- Accepts a byte stream (from a UART receiver or host link) over a valid/ready handshake.
- Assembles big-endian 16-bit instruction words and writes them sequentially into the instruction memory write port.
- Holds the CPU in reset while a load is in progress.

---
 rtl/simple_pkg.sv | 21 ++
 rtl/loader_word_assembler.sv | 40 ++++
 rtl/imem_loader.sv | 166 ++++++++++++++++
 tb/tb_imem_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simple_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Consumed by imem_loader and loader_word_assembler.
package simple_pkg;

  localparam int         IMEM_ADDR_W = 12;
  localparam int         IMEM_DEPTH  = 1 << IMEM_ADDR_W;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;

  typedef enum logic [3:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA_HI,
    DATA_LO,
    CK_HI,
    CK_LO,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// Pairs a high and a low byte into a big-endian 16-bit word; word_valid pulses for
// one cycle, the cycle after the low byte is latched.
module loader_word_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        latch_hi,
  input  logic        latch_lo,
  output logic [15:0] word,
  output logic        word_valid
);

  logic [7:0]  hi_q, hi_d;
  logic [15:0] word_q, word_d;
  logic        valid_q, valid_d;

  always_comb begin
    hi_d    = hi_q;
    word_d  = word_q;
    valid_d = latch_lo;
    if (latch_hi) hi_d = byte_in;
    if (latch_lo) word_d = {hi_q, byte_in};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q    <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hi_q    <= hi_d;
      word_q  <= word_d;
      valid_q <= valid_d;
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Program loader: receives an A5-framed byte stream and writes big-endian 16-bit words
// into instruction memory while holding the CPU in reset. IMEM_LOADER_CKSUM_EN adds a checksum.
module imem_loader
  import simple_pkg::*;
#(
  parameter int         ADDR_W    = IMEM_ADDR_W,
  parameter int         DEPTH     = IMEM_DEPTH,
  parameter logic [7:0] SYNC_BYTE = simple_pkg::SYNC_BYTE
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              load_req,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  state_t            state_q, state_d;
  state_t            after_data;
  logic [15:0]       len_q, len_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              latch_hi, latch_lo;
  logic [15:0]       word;
  logic              word_valid;

`ifdef IMEM_LOADER_CKSUM_EN
  logic [15:0] sum_q, sum_d;
  logic [7:0]  ck_hi_q, ck_hi_d;
  assign after_data = CK_HI;
`else
  assign after_data = DONE;
`endif

  always_comb begin
    // NOTE: every signal gets a default here so no path through the case infers a latch.
    state_d    = state_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    wr_addr_d  = wr_addr_q;
    cpu_hold_d = cpu_hold_q;
    done_d     = done_q;
    error_d    = error_q;
    latch_hi   = 1'b0;
    latch_lo   = 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    ck_hi_d = ck_hi_q;
    sum_d   = word_valid ? sum_q + word : sum_q;
`endif

    if ((state_q == DONE || state_q == ERR) && load_req) begin
      state_d    = IDLE;
      done_d     = 1'b0;
      error_d    = 1'b0;
      cpu_hold_d = 1'b0;
    end else if (in_valid) begin
      unique case (state_q)
        IDLE: begin
          if (in_data == SYNC_BYTE) begin
            state_d    = LEN_HI;
            cpu_hold_d = 1'b1;
            cnt_d      = '0;
`ifdef IMEM_LOADER_CKSUM_EN
            sum_d      = '0;
`endif
          end
        end
        LEN_HI: begin
          len_d   = {in_data, len_q[7:0]};
          state_d = LEN_LO;
        end
        LEN_LO: begin
          len_d = {len_q[15:8], in_data};
          if (len_d == '0)                state_d = after_data;
          else if (len_d > 16'(DEPTH))    state_d = ERR;
          else                            state_d = DATA_HI;
        end
        DATA_HI: begin
          latch_hi = 1'b1;
          state_d  = DATA_LO;
        end
        DATA_LO: begin
          // The write strobe comes out of the assembler one cycle later, with this address.
          latch_lo  = 1'b1;
          wr_addr_d = cnt_q[ADDR_W-1:0];
          cnt_d     = cnt_q + 16'd1;
          state_d   = (cnt_d == len_q) ? after_data : DATA_HI;
        end
`ifdef IMEM_LOADER_CKSUM_EN
        CK_HI: begin
          ck_hi_d = in_data;
          state_d = CK_LO;
        end
        CK_LO: state_d = ({ck_hi_q, in_data} == sum_q) ? DONE : ERR;
`endif
        default: ;  // DONE and ERR swallow bytes
      endcase
    end

    if (state_d == DONE) begin
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
    end
    if (state_d == ERR) begin
      error_d    = 1'b1;
      cpu_hold_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments so every flop samples the same pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      wr_addr_q  <= '0;
      cpu_hold_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q      <= '0;
      ck_hi_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      wr_addr_q  <= wr_addr_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CKSUM_EN
      sum_q      <= sum_d;
      ck_hi_q    <= ck_hi_d;
`endif
    end
  end

  loader_word_assembler u_asm (
    .clock      (clock),
    .reset      (reset),
    .byte_in    (in_data),
    .latch_hi   (latch_hi),
    .latch_lo   (latch_lo),
    .word       (word),
    .word_valid (word_valid)
  );

  assign in_ready = 1'b1;
  assign wr_en    = word_valid;
  assign wr_data  = word;
  assign wr_addr  = wr_addr_q;
  assign cpu_hold = cpu_hold_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames, a vector table, a full-depth load
// and randomized frames against a word-list reference model.
module tb_imem_loader;

  localparam logic [7:0] SYNC  = 8'hA5;
  localparam int         DEPTH = 4096;

  logic        clock, reset;
  logic [7:0]  in_data;
  logic        in_valid, in_ready, load_req;
  logic        wr_en;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  logic        cpu_hold, done, error;

  int checks   = 0;
  int failures = 0;
  bit lr_en    = 1'b0;

  logic [27:0] got_q[$];        // observed writes {addr, data}
  logic [15:0] frame_words[$];  // words of the frame being sent

  typedef struct {
    logic [15:0] len;
    logic [7:0]  junk;
    bit          exp_done;
    bit          exp_err;
    int          exp_wr;
  } vec_t;
  vec_t vt[6];

  imem_loader dut (
    .clock    (clock),
    .reset    (reset),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .load_req (load_req),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock)
    if (!reset && wr_en) got_q.push_back({wr_addr, wr_data});

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic put(input logic [7:0] b);
    in_data  = b;
    in_valid = 1'b1;
    load_req = lr_en && ($urandom_range(0, 3) == 0);
    @(negedge clock);
    in_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic put_g(input logic [7:0] b, input int gap);
    int g;
    g = (gap > 0) ? $urandom_range(0, gap) : 0;
    repeat (g) begin
      in_data  = 8'($urandom);
      load_req = lr_en && ($urandom_range(0, 3) == 0);
      @(negedge clock);
      load_req = 1'b0;
    end
    put(b);
  endtask

  task automatic pulse_load_req();
    load_req = 1'b1;
    @(negedge clock);
    load_req = 1'b0;
  endtask

  task automatic gen_words(input logic [15:0] len);
    frame_words.delete();
    if (len <= 16'(DEPTH))
      for (int i = 0; i < int'(len); i++) frame_words.push_back(16'($urandom));
  endtask

  // Sends sync, length, frame_words and (when enabled) the checksum, optionally corrupted.
  task automatic send_frame(input logic [15:0] len, input bit bad_ck, input int gap);
    logic [15:0] sum;
    sum = '0;
    put_g(SYNC, gap);
    put_g(len[15:8], gap);
    put_g(len[7:0], gap);
    if (len <= 16'(DEPTH)) begin
      foreach (frame_words[i]) begin
        put_g(frame_words[i][15:8], gap);
        put_g(frame_words[i][7:0], gap);
        sum += frame_words[i];
      end
`ifdef IMEM_LOADER_CKSUM_EN
      if (bad_ck) sum += 16'd1;
      put_g(sum[15:8], gap);
      put_g(sum[7:0], gap);
`endif
    end
  endtask

  // Reference model outcome: lengths beyond DEPTH are rejected; with checksum, a bad sum is rejected.
  function automatic bit exp_ok(input logic [15:0] len, input bit bad_ck);
    if (len > 16'(DEPTH)) return 1'b0;
`ifdef IMEM_LOADER_CKSUM_EN
    return !bad_ck;
`else
    return 1'b1;
`endif
  endfunction

  // Word i of the frame must land at address i, in order, exactly once.
  task automatic compare_writes(input string tag, input int n);
    check({tag, "_count"}, got_q.size(), n);
    for (int i = 0; i < n && i < got_q.size(); i++) begin
      check({tag, "_addr"}, got_q[i][27:16], 32'(i));
      check({tag, "_data"}, got_q[i][15:0], frame_words[i]);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = '0; load_req = 1'b0;
    vt[0] = '{16'd2,    8'h3C, 1'b1, 1'b0, 2};
    vt[1] = '{16'd0,    8'hFF, 1'b1, 1'b0, 0};
    vt[2] = '{16'd1,    8'h5A, 1'b1, 1'b0, 1};
    vt[3] = '{16'h1001, 8'h00, 1'b0, 1'b1, 0};
    vt[4] = '{16'hFFFF, 8'h7E, 1'b0, 1'b1, 0};
    vt[5] = '{16'd7,    8'hA4, 1'b1, 1'b0, 7};

    #7;
    check("rst_in_ready", in_ready, 1);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    @(negedge clock);
    reset = 1'b0;
    idle(1);

    // Frame A5 00 02 12 34 AB CD, cycle by cycle
    frame_words = {16'h1234, 16'hABCD};
    got_q.delete();
    put(SYNC);
    check("hold_after_sync", cpu_hold, 1);
    put(8'h00); put(8'h02); put(8'h12);
    check("no_write_on_hi", wr_en, 0);
    put(8'h34);
    check("w0_en", wr_en, 1);
    check("w0_addr", wr_addr, 12'h000);
    check("w0_data", wr_data, 16'h1234);
    check("w0_hold", cpu_hold, 1);
    put(8'hAB);
    check("wr_pulse_single", wr_en, 0);
    check("wr_addr_holds", wr_addr, 12'h000);
    put(8'hCD);
    check("w1_en", wr_en, 1);
    check("w1_addr", wr_addr, 12'h001);
    check("w1_data", wr_data, 16'hABCD);
`ifdef IMEM_LOADER_CKSUM_EN
    check("done_before_ck", done, 0);
    check("hold_before_ck", cpu_hold, 1);
    put(8'hBE); put(8'h01);
`endif
    check("frameA_done", done, 1);
    check("frameA_hold_drop", cpu_hold, 0);
    check("frameA_error", error, 0);
    idle(2);
    compare_writes("frameA", 2);
    pulse_load_req();
    check("frameA_cleared", done, 0);

    // Vector table: junk before sync, legal/empty/oversize lengths, bytes ignored after the frame
    for (int i = 0; i < 6; i++) begin
      int n_before;
      gen_words(vt[i].len);
      got_q.delete();
      put(8'h00);
      put(vt[i].junk);
      send_frame(vt[i].len, 1'b0, 0);
      idle(2);
      check("vec_done", done, vt[i].exp_done);
      check("vec_error", error, vt[i].exp_err);
      check("vec_hold", cpu_hold, vt[i].exp_err);
      compare_writes("vec", vt[i].exp_wr);
      n_before = got_q.size();
      put(SYNC); put(8'h00); put(8'h01); idle(1);
      check("vec_ignored_hold", cpu_hold, vt[i].exp_err);
      check("vec_ignored_writes", got_q.size(), n_before);
      pulse_load_req();
      check("vec_clear_done", done, 0);
      check("vec_clear_error", error, 0);
      check("vec_clear_hold", cpu_hold, 0);
    end

    // Reset in the middle of a 3-word frame, after two words are written
    frame_words = {16'h1122, 16'h3344, 16'h5566};
    got_q.delete();
    put(SYNC); put(8'h00); put(8'h03);
    put(8'h11); put(8'h22); put(8'h33); put(8'h44); put(8'h55);
    #1 reset = 1'b1;
    #1;
    check("arst_wr_en", wr_en, 0);
    check("arst_wr_addr", wr_addr, 0);
    check("arst_wr_data", wr_data, 0);
    check("arst_hold", cpu_hold, 0);
    check("arst_done", done, 0);
    check("arst_error", error, 0);
    check("arst_in_ready", in_ready, 1);
    @(negedge clock);
    reset = 1'b0;
    idle(1);
    compare_writes("arst_pre", 2);
    frame_words = {16'hBEEF};
    got_q.delete();
    send_frame(16'd1, 1'b0, 0);
    idle(2);
    compare_writes("arst_post", 1);
    check("arst_post_done", done, 1);
    pulse_load_req();

`ifdef IMEM_LOADER_CKSUM_EN
    frame_words = {16'h0001, 16'h0002};
    got_q.delete();
    send_frame(16'd2, 1'b0, 0);
    idle(2);
    check("ck_good_done", done, 1);
    check("ck_good_error", error, 0);
    compare_writes("ck_good", 2);
    pulse_load_req();
    got_q.delete();
    send_frame(16'd2, 1'b1, 0);
    idle(2);
    check("ck_bad_error", error, 1);
    check("ck_bad_hold", cpu_hold, 1);
    check("ck_bad_done", done, 0);
    compare_writes("ck_bad", 2);
    pulse_load_req();
`endif

    // Full-depth frame with in_valid held high throughout
    frame_words.delete();
    for (int i = 0; i < DEPTH; i++) frame_words.push_back(16'(i * 7 + 3));
    got_q.delete();
    send_frame(16'h1000, 1'b0, 0);
    idle(2);
    compare_writes("full", DEPTH);
    if (got_q.size() > 0) check("full_last_addr", got_q[got_q.size()-1][27:16], 12'hFFF);
    check("full_done", done, 1);
    check("full_hold", cpu_hold, 0);
    pulse_load_req();

    // Randomized frames with gaps, junk and stray load_req pulses while active
    for (int f = 0; f < 30; f++) begin
      logic [15:0] len;
      logic [7:0]  junk;
      bit          bad, ok;
      int          nj;
      case ($urandom_range(0, 9))
        0:       len = 16'd0;
        1:       len = 16'(4097 + $urandom_range(0, 3000));
        default: len = 16'($urandom_range(1, 40));
      endcase
      bad = 1'($urandom_range(0, 1));
      gen_words(len);
      got_q.delete();
      lr_en = 1'b1;
      nj = $urandom_range(0, 3);
      repeat (nj) begin
        junk = 8'($urandom);
        if (junk == SYNC) junk = 8'h5A;
        put_g(junk, 2);
      end
      send_frame(len, bad, 2);
      lr_en = 1'b0;
      idle(2);
      ok = exp_ok(len, bad);
      check("rnd_done", done, ok);
      check("rnd_error", error, !ok);
      check("rnd_hold", cpu_hold, !ok);
      compare_writes("rnd", (len <= 16'(DEPTH)) ? int'(len) : 0);
      pulse_load_req();
      check("rnd_cleared", {done, error, cpu_hold}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
